// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory port between the IF stage and imem.
//   req_valid  fetch side -> mem   request valid
//   req_addr   fetch side -> mem   fetch address
//   req_ready  mem -> fetch side   memory accepts request
//   resp_valid mem -> fetch side   instruction returned (>=1 cycle after accept)
//   resp_data  mem -> fetch side   instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;

    modport master (output req_valid, req_addr, input  req_ready, resp_valid, resp_data);
    modport slave  (input  req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage. Owns the PC, issues one-outstanding fetches over the
// imem interface and presents the IF/ID register {valid, pc, inst} to decode.
// A one-entry hold buffer catches a response that arrives while decode is
// stalled on a full IF/ID; issue is blocked while the hold buffer is full.
// flush_needed_i kills IF/ID, the hold buffer and any in-flight fetch.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   new_pc_i            next PC from the PC generator
//   flush_needed_i      redirect; highest priority, overrides stall
//   stall_i             decode stall, IF/ID holds
//   pc_o                current fetch PC
//   imem                fetch_stage_if.master instruction-memory port
//   ifid_valid_o/pc_o/inst_o  IF/ID pipeline register
// Optional: define FETCH_PERF_CNT_EN to add perf_fetch_cnt_o / perf_drop_cnt_o.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013,
    parameter int          PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           new_pc_i,
    input  logic                  flush_needed_i,
    input  logic                  stall_i,
    output logic [31:0]           pc_o,
    fetch_stage_if.master         imem,
    output logic                  ifid_valid_o,
    output logic [31:0]           ifid_pc_o,
    output logic [31:0]           ifid_inst_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_fetch_cnt_o,
    output logic [PERF_CNT_W-1:0] perf_drop_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // may issue
        S_WAIT  = 2'd1,   // one fetch outstanding
        S_DRAIN = 2'd2    // outstanding response is stale, discard it
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    logic req_valid;
    logic fire;
    logic resp_live;   // response for a live fetch this cycle
    logic resp_drop;   // response being discarded this cycle

    always_comb begin
        req_valid = (state_q == S_IDLE) & ~hold_valid_q & ~flush_needed_i;
        fire      = req_valid & imem.req_ready;
        resp_live = (state_q == S_WAIT) & imem.resp_valid;
        resp_drop = imem.resp_valid &
                    ((state_q == S_DRAIN) | ((state_q == S_WAIT) & flush_needed_i));
    end

    assign imem.req_valid = req_valid;
    assign imem.req_addr  = pc_q;
    assign pc_o           = pc_q;
    assign ifid_valid_o   = ifid_valid_q;
    assign ifid_pc_o      = ifid_pc_q;
    assign ifid_inst_o    = ifid_inst_q;

    // IF/ID and hold buffer next state. The hold buffer is empty whenever a
    // fetch is outstanding (issue waits for it), so a response never meets a
    // full hold buffer.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;
        if (flush_needed_i) begin
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP_INST;
            hold_valid_d = 1'b0;
        end else if (!stall_i) begin
            if (hold_valid_q) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = hold_pc_q;
                ifid_inst_d  = hold_inst_q;
                hold_valid_d = 1'b0;
            end else if (resp_live) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = req_pc_q;
                ifid_inst_d  = imem.resp_data;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_inst_d  = NOP_INST;
            end
        end else if (resp_live) begin
            // stalled: an empty IF/ID may still be filled, otherwise park it
            if (!ifid_valid_q) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = req_pc_q;
                ifid_inst_d  = imem.resp_data;
            end else begin
                hold_valid_d = 1'b1;
                hold_pc_d    = req_pc_q;
                hold_inst_d  = imem.resp_data;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] fetch_cnt_q, drop_cnt_q;
    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_drop_cnt_o  = drop_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'h0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_inst_q  <= NOP_INST;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= 32'h0;
            hold_inst_q  <= NOP_INST;
`ifdef FETCH_PERF_CNT_EN
            fetch_cnt_q  <= '0;
            drop_cnt_q   <= '0;
`endif
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;

            // fire and flush are exclusive (flush gates req_valid)
            if (flush_needed_i) begin
                pc_q <= new_pc_i;
            end else if (fire) begin
                pc_q     <= new_pc_i;
                req_pc_q <= pc_q;
            end

            case (state_q)
                S_IDLE:  if (fire) state_q <= S_WAIT;
                S_WAIT: begin
                    if (imem.resp_valid)     state_q <= S_IDLE;
                    else if (flush_needed_i) state_q <= S_DRAIN;
                end
                S_DRAIN: if (imem.resp_valid) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

`ifdef FETCH_PERF_CNT_EN
            if (fire)      fetch_cnt_q <= fetch_cnt_q + 1'b1;
            if (resp_drop) drop_cnt_q  <= drop_cnt_q + 1'b1;
`endif
        end
    end

`ifndef FETCH_PERF_CNT_EN
    logic unused_drop;
    assign unused_drop = resp_drop;
`endif

`ifndef SYNTHESIS
    // a response with nothing outstanding is a memory protocol violation
    a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst)
        !((state_q == S_IDLE) && imem.resp_valid));
`endif

endmodule
